// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder one-hot channel driver.
package scan_decoder_pkg;

  localparam int unsigned MAX_CH = 256;
  localparam int unsigned IDX_W  = 8;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  // Wide one-hot; callers truncate to their channel count.
  function automatic logic [MAX_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [MAX_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scan_decoder_prescaler.sv
// DIV-cycle tick generator with synchronous clear; tick_c is high on the last count.
module scan_decoder_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick_c = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick_c ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct and autonomous scan modes.
// Build option: SCAN_DECODER_ACTIVE_LOW_EN drives Dout inverted for common-anode displays.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DIV    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic [SEL_W-1:0]  A,
  output logic [NUM_CH-1:0] Dout,
  output logic [SEL_W-1:0]  cur_sel,
  output logic              wrap
);

  localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W + 1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  localparam logic [NUM_CH-1:0] DOUT_POL = '1;
`else
  localparam logic [NUM_CH-1:0] DOUT_POL = '0;
`endif

  state_e              state_q;
  state_e              state_n;
  logic [NUM_CH-1:0]   dout_n;
  logic [SEL_W-1:0]    sel_n;
  logic                wrap_n;
  logic                a_ok;
  logic                pre_clr;
  logic                pre_en;
  logic                tick_c;

  scan_decoder_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (pre_clr),
    .en     (pre_en),
    .tick_c (tick_c)
  );

  // Next state and next registered outputs; dout_n is active-high here.
  always_comb begin
    state_n = IDLE;
    dout_n  = '0;
    sel_n   = cur_sel;
    wrap_n  = 1'b0;
    pre_clr = 1'b1;
    pre_en  = 1'b0;
    a_ok    = ({1'b0, A} < NUM_CH_X);

    if (enable) begin
      state_n = (mode == MODE_DIRECT) ? DIRECT : SCAN;
    end

    case (state_n)
      DIRECT: begin
        if (a_ok) begin
          sel_n  = A;
          dout_n = NUM_CH'(onehot(IDX_W'(A)));
        end
      end
      SCAN: begin
        if (state_q != SCAN) begin
          sel_n = a_ok ? A : '0;
        end else begin
          pre_clr = 1'b0;
          pre_en  = 1'b1;
          if (tick_c) begin
            if (cur_sel == LAST_SEL) begin
              sel_n  = '0;
              wrap_n = 1'b1;
            end else begin
              sel_n = cur_sel + SEL_W'(1);
            end
          end
        end
        dout_n = NUM_CH'(onehot(IDX_W'(sel_n)));
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      Dout    <= DOUT_POL;
      cur_sel <= '0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_n;
      Dout    <= dout_n ^ DOUT_POL;
      cur_sel <= sel_n;
      wrap    <= wrap_n;
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Randomised self-checking bench for scan_decoder (8ch/DIV=4 and 6ch/DIV=1 instances).
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, en0, md0;
  logic [2:0] a0;
  logic [7:0] d0;
  logic [2:0] s0;
  logic       w0;

  logic       rst1, en1, md1;
  logic [2:0] a1;
  logic [5:0] d1;
  logic [2:0] s1;
  logic       w1;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  localparam logic [7:0] POL0 = 8'hFF;
  localparam logic [5:0] POL1 = 6'h3F;
`else
  localparam logic [7:0] POL0 = 8'h00;
  localparam logic [5:0] POL1 = 6'h00;
`endif

  scan_decoder #(.SEL_W(3), .NUM_CH(8), .DIV(4)) u_dut0 (
    .clk(clk), .rst(rst0), .enable(en0), .mode(md0), .A(a0),
    .Dout(d0), .cur_sel(s0), .wrap(w0)
  );

  scan_decoder #(.SEL_W(3), .NUM_CH(6), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst1), .enable(en1), .mode(md1), .A(a1),
    .Dout(d1), .cur_sel(s1), .wrap(w1)
  );

  int tests = 0;
  int fails = 0;

  // Reference: in scan, position = start + (cycles since entry) / DIV, modulo channel count.
  int m_sel[2];
  int m_dout[2];
  int m_wrap[2];
  int m_k[2];
  int m_start[2];
  bit m_scan[2];

  task automatic model_step(input int i, input int n, input int dv,
                            input logic r, input logic e, input logic m, input int a);
    if (r) begin
      m_sel[i] = 0; m_dout[i] = 0; m_wrap[i] = 0; m_scan[i] = 0;
    end else if (!e) begin
      m_dout[i] = 0; m_wrap[i] = 0; m_scan[i] = 0;
    end else if (!m) begin
      m_scan[i] = 0; m_wrap[i] = 0;
      if (a < n) begin
        m_sel[i] = a; m_dout[i] = 1 << a;
      end else begin
        m_dout[i] = 0;
      end
    end else begin
      if (!m_scan[i]) begin
        m_scan[i] = 1; m_start[i] = (a < n) ? a : 0; m_k[i] = 0;
      end else begin
        m_k[i]++;
      end
      m_sel[i]  = (m_start[i] + m_k[i] / dv) % n;
      m_wrap[i] = (m_k[i] > 0 && m_k[i] % dv == 0 && m_sel[i] == 0) ? 1 : 0;
      m_dout[i] = 1 << m_sel[i];
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 8, 4, rst0, en0, md0, int'(a0));
    model_step(1, 6, 1, rst1, en1, md1, int'(a1));
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  bit chk_on = 1'b0;

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      check("dout0", int'(d0), m_dout[0] ^ int'(POL0));
      check("sel0", int'(s0), m_sel[0]);
      check("wrap0", int'(w0), m_wrap[0]);
      check("onehot0", ($countones(d0 ^ POL0) <= 1) ? 1 : 0, 1);
      check("dout1", int'(d1), m_dout[1] ^ int'(POL1));
      check("sel1", int'(s1), m_sel[1]);
      check("wrap1", int'(w1), m_wrap[1]);
      check("onehot1", ($countones(d1 ^ POL1) <= 1) ? 1 : 0, 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int seq6[7];
    seq6 = '{0, 1, 2, 3, 4, 5, 0};
    rst0 = 1'b1; en0 = 1'b0; md0 = 1'b0; a0 = 3'd0;
    rst1 = 1'b1; en1 = 1'b0; md1 = 1'b0; a1 = 3'd0;
    cyc(2);
    chk_on = 1'b1;
    check("rst_dout0", int'(d0), int'(POL0));
    check("rst_sel0", int'(s0), 0);
    check("rst_wrap0", int'(w0), 0);

    // Direct sweep, each value held two cycles.
    rst0 = 1'b0; en0 = 1'b1; md0 = 1'b0;
    for (int a = 0; a < 8; a++) begin
      a0 = 3'(a);
      if (a > 0) check("sweep_lag", int'(d0), (1 << (a - 1)) ^ int'(POL0));
      cyc(2);
      check("sweep_dout", int'(d0), (1 << a) ^ int'(POL0));
      check("sweep_sel", int'(s0), a);
    end
    check("sweep_last", int'(d0), int'(8'h80 ^ POL0));

    // Enable low: outputs off, selection held.
    en0 = 1'b0;
    for (int a = 0; a < 8; a++) begin
      a0 = 3'(a);
      cyc(1);
      check("off_dout", int'(d0), int'(POL0));
      check("off_sel", int'(s0), 7);
    end

    // Scan from 6 with DIV=4.
    en0 = 1'b1; md0 = 1'b1; a0 = 3'd6;
    cyc(1); check("scan_start", int'(s0), 6);
    cyc(3); check("scan_hold", int'(s0), 6);
    cyc(1); check("scan_step7", int'(s0), 7);
    cyc(4); check("scan_wrap_sel", int'(s0), 0);
    check("scan_wrap_pulse", int'(w0), 1);
    check("scan_wrap_dout", int'(d0), int'(8'h01 ^ POL0));
    cyc(1); check("scan_wrap_end", int'(w0), 0);
    cyc(11); check("scan_at3", int'(s0), 3);

    // Reset mid-scan, then restart from A=0.
    rst0 = 1'b1; a0 = 3'd0;
    cyc(1);
    check("mrst_dout", int'(d0), int'(POL0));
    check("mrst_sel", int'(s0), 0);
    check("mrst_wrap", int'(w0), 0);
    rst0 = 1'b0;
    cyc(1); check("restart_sel", int'(s0), 0);
    check("restart_dout", int'(d0), int'(8'h01 ^ POL0));
    cyc(4); check("restart_step", int'(s0), 1);

    // Six channels, DIV=1.
    rst1 = 1'b0; en1 = 1'b1; md1 = 1'b1; a1 = 3'd0;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      check("ch6_sel", int'(s1), seq6[i]);
      check("ch6_wrap", int'(w1), (i == 6) ? 1 : 0);
    end
    md1 = 1'b0; a1 = 3'd3;
    cyc(1); check("ch6_direct", int'(s1), 3);
    a1 = 3'd6;
    cyc(1); check("ch6_a6_dout", int'(d1), int'(POL1));
    check("ch6_a6_sel", int'(s1), 3);
    a1 = 3'd7;
    cyc(1); check("ch6_a7_dout", int'(d1), int'(POL1));
    check("ch6_a7_sel", int'(s1), 3);

    // Random traffic on both instances with sticky mode/enable.
    for (int i = 0; i < 600; i++) begin
      rst0 = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) en0 = ~en0;
      if ($urandom_range(0, 15) == 0) md0 = ~md0;
      a0 = 3'($urandom);
      rst1 = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) en1 = ~en1;
      if ($urandom_range(0, 11) == 0) md1 = ~md1;
      a1 = 3'($urandom);
      cyc(1);
    end

    cyc(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
